// File: rtl/blinky_pkg.sv
// Shared definitions for the button/LED blocks: decoder FSM state encoding and
// default tick counts derived from the 27 MHz board clock.
package blinky_pkg;

    localparam int C_FREQ_HZ      = 27_000_000;
    localparam int DEBOUNCE_MS    = 10;
    localparam int LONG_MS        = 1000;
    localparam int DEBOUNCE_TICKS = (C_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_TICKS     = (C_FREQ_HZ / 1000) * LONG_MS;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        LONG_HELD    = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_e;

endpackage

// File: rtl/button_press_decoder_if.sv
// Bundle of the raw button pin and the clean events produced from it.
// master = decoder side, slave = logic consuming the events.
interface button_press_decoder_if;

    logic button;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic toggle;

    modport master (
        input  button,
        output pressed, press_pulse, release_pulse, long_pulse, toggle
    );

    modport slave (
        output button,
        input  pressed, press_pulse, release_pulse, long_pulse, toggle
    );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchronizer for asynchronous pins; the reset value should be the
// pin's idle level so no phantom edge appears when reset is released.
module button_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_press_decoder.sv
// Debounces one raw push-button pin and turns it into clock-synchronous
// press/release/long-press pulses, a debounced level and a short-press toggle.
module button_press_decoder
    import blinky_pkg::*;
#(
    parameter int C_DEBOUNCE_TICKS = DEBOUNCE_TICKS,
    parameter int C_LONG_TICKS     = LONG_TICKS,
    parameter bit C_ACTIVE_LOW     = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_toggle
);

    localparam int DW = $clog2(C_DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(C_LONG_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(C_DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(C_LONG_TICKS - 1);

    logic [0:0] pin_sync;
    logic       act;

    button_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'(C_ACTIVE_LOW))
    ) u_sync (
        .clk_i  (i_clock),
        .rst_ni (i_reset_n),
        .d_i    (i_button),
        .q_o    (pin_sync)
    );

    assign act = pin_sync[0] ^ C_ACTIVE_LOW;

    btn_state_e      state_q, state_d, prev_q;
    logic [DW-1:0]   deb_q, deb_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            long_q, long_d;

    // prev_q lets the output stage see each transition exactly once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            prev_q  <= IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        long_d  = long_q;
        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_WAIT;
                    deb_d   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    hold_d  = '0;
                    long_d  = 1'b0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = RELEASE_WAIT;
                    deb_d   = DW'(1);
                end else if (hold_q == HOLD_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LONG_HELD: begin
                if (!act) begin
                    state_d = RELEASE_WAIT;
                    deb_d   = DW'(1);
                end
            end
            RELEASE_WAIT: begin
                // A bounce returns to the held state without any pulse.
                if (act) begin
                    state_d = long_q ? LONG_HELD : HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic pressed_d, press_d, release_d, long_pulse_d, toggle_d;
    logic pressed_q, press_q, release_q, long_pulse_q, toggle_q;

    always_comb begin
        pressed_d    = (state_q == HELD) || (state_q == LONG_HELD) ||
                       (state_q == RELEASE_WAIT);
        press_d      = (prev_q == PRESS_WAIT) && (state_q == HELD);
        long_pulse_d = (prev_q == HELD) && (state_q == LONG_HELD);
        release_d    = (prev_q == RELEASE_WAIT) && (state_q == IDLE);
        toggle_d     = toggle_q ^ (release_d && !long_q);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pressed_q    <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_pulse_q <= 1'b0;
            toggle_q     <= 1'b0;
        end else begin
            pressed_q    <= pressed_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_pulse_q <= long_pulse_d;
            toggle_q     <= toggle_d;
        end
    end

    assign o_pressed       = pressed_q;
    assign o_press_pulse   = press_q;
    assign o_release_pulse = release_q;
    assign o_long_pulse    = long_pulse_q;
    assign o_toggle        = toggle_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: pin segments with hand-computed pulse counts
// and positions, plus a hand-written reset-while-held sequence.
module tb_button_press_decoder;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_press_decoder_if bus ();

    button_press_decoder #(
        .C_DEBOUNCE_TICKS (DEB),
        .C_LONG_TICKS     (LONG),
        .C_ACTIVE_LOW     (1'b1)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_button        (bus.button),
        .o_pressed       (bus.pressed),
        .o_press_pulse   (bus.press_pulse),
        .o_release_pulse (bus.release_pulse),
        .o_long_pulse    (bus.long_pulse),
        .o_toggle        (bus.toggle)
    );

    // Positions are counted from the first clock edge that samples the new pin level.
    typedef struct {
        logic pin;
        int   cycles;
        int   press_cnt;
        int   press_at;
        int   rel_cnt;
        int   rel_at;
        int   long_cnt;
        int   long_at;
        int   hi_cnt;
        int   pressed_end;
        int   toggle_rel;
        int   toggle_end;
    } seg_t;

    int n_checks = 0;
    int n_fail   = 0;

    int press_cnt, press_at, rel_cnt, rel_at, long_cnt, long_at, hi_cnt, tog_rel;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic run_seg(input logic pin, input int n);
        bus.button = pin;
        press_cnt = 0; press_at = -1;
        rel_cnt   = 0; rel_at   = -1;
        long_cnt  = 0; long_at  = -1;
        hi_cnt    = 0; tog_rel  = -1;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.press_pulse) begin
                press_cnt++;
                if (press_at < 0) press_at = j;
            end
            if (bus.release_pulse) begin
                rel_cnt++;
                if (rel_at < 0) rel_at = j;
                tog_rel = int'(bus.toggle);
            end
            if (bus.long_pulse) begin
                long_cnt++;
                if (long_at < 0) long_at = j;
            end
            hi_cnt += int'(bus.pressed);
            check("sep_press_release", int'(bus.press_pulse & bus.release_pulse), 0);
            check("sep_long", int'(bus.long_pulse & (bus.press_pulse | bus.release_pulse)), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pressed"}, int'(bus.pressed), 0);
        check({tag, "_press"},   int'(bus.press_pulse), 0);
        check({tag, "_release"}, int'(bus.release_pulse), 0);
        check({tag, "_long"},    int'(bus.long_pulse), 0);
        check({tag, "_toggle"},  int'(bus.toggle), 0);
    endtask

    function automatic seg_t mk(input logic pin, input int cycles,
                                input int pc, input int pa, input int rc, input int ra,
                                input int lc, input int la, input int hi, input int pe,
                                input int tr, input int te);
        seg_t s;
        s.pin = pin;       s.cycles = cycles;
        s.press_cnt = pc;  s.press_at = pa;
        s.rel_cnt = rc;    s.rel_at = ra;
        s.long_cnt = lc;   s.long_at = la;
        s.hi_cnt = hi;     s.pressed_end = pe;
        s.toggle_rel = tr; s.toggle_end = te;
        return s;
    endfunction

    seg_t segs[18];

    initial begin
        //             pin   cyc  pc pa  rc ra  lc la  hi  pe  tr  te
        segs[0]  = mk(1'b1, 50,  0, -1, 0, -1, 0, -1, 0,  0, -1, 0); // idle
        segs[1]  = mk(1'b0, 2,   0, -1, 0, -1, 0, -1, 0,  0, -1, 0); // glitch
        segs[2]  = mk(1'b1, 20,  0, -1, 0, -1, 0, -1, 0,  0, -1, 0);
        segs[3]  = mk(1'b0, 10,  1, 6,  0, -1, 0, -1, 4,  1, -1, 0); // short press
        segs[4]  = mk(1'b1, 20,  0, -1, 1, 6,  0, -1, 6,  0, 1,  1);
        segs[5]  = mk(1'b0, 10,  1, 6,  0, -1, 0, -1, 4,  1, -1, 1); // bouncy release
        segs[6]  = mk(1'b1, 1,   0, -1, 0, -1, 0, -1, 1,  1, -1, 1);
        segs[7]  = mk(1'b0, 1,   0, -1, 0, -1, 0, -1, 1,  1, -1, 1);
        segs[8]  = mk(1'b1, 1,   0, -1, 0, -1, 0, -1, 1,  1, -1, 1);
        segs[9]  = mk(1'b0, 11,  0, -1, 0, -1, 0, -1, 11, 1, -1, 1);
        segs[10] = mk(1'b1, 20,  0, -1, 1, 6,  0, -1, 6,  0, 0,  0);
        segs[11] = mk(1'b0, 40,  1, 6,  0, -1, 1, 26, 34, 1, -1, 0); // long press
        segs[12] = mk(1'b1, 20,  0, -1, 1, 6,  0, -1, 6,  0, 0,  0);
        segs[13] = mk(1'b0, 10,  1, 6,  0, -1, 0, -1, 4,  1, -1, 0);
        segs[14] = mk(1'b1, 20,  0, -1, 1, 6,  0, -1, 6,  0, 1,  1);
        segs[15] = mk(1'b0, 10,  1, 6,  0, -1, 0, -1, 4,  1, -1, 1); // held, then reset
        segs[16] = mk(1'b0, 30,  1, 6,  0, -1, 1, 26, 24, 1, -1, 0); // after reset
        segs[17] = mk(1'b0, 40,  0, -1, 0, -1, 0, -1, 40, 1, -1, 0); // stuck pressed

        bus.button = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (i == 16) begin
                // Reset lands asynchronously in the middle of a held press.
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid_now");
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_all_zero("rst_mid_hold");
                end
                rst_n = 1'b1;
            end
            run_seg(segs[i].pin, segs[i].cycles);
            check($sformatf("s%0d_press_cnt", i), press_cnt, segs[i].press_cnt);
            if (segs[i].press_at >= 0)
                check($sformatf("s%0d_press_at", i), press_at, segs[i].press_at);
            check($sformatf("s%0d_rel_cnt", i), rel_cnt, segs[i].rel_cnt);
            if (segs[i].rel_at >= 0)
                check($sformatf("s%0d_rel_at", i), rel_at, segs[i].rel_at);
            check($sformatf("s%0d_long_cnt", i), long_cnt, segs[i].long_cnt);
            if (segs[i].long_at >= 0)
                check($sformatf("s%0d_long_at", i), long_at, segs[i].long_at);
            if (segs[i].toggle_rel >= 0)
                check($sformatf("s%0d_toggle_at_rel", i), tog_rel, segs[i].toggle_rel);
            check($sformatf("s%0d_pressed_cycles", i), hi_cnt, segs[i].hi_cnt);
            check($sformatf("s%0d_pressed_end", i), int'(bus.pressed), segs[i].pressed_end);
            check($sformatf("s%0d_toggle_end", i), int'(bus.toggle), segs[i].toggle_end);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
